// File: rtl/cdc_write_packer_if.sv
// Handshake and FIFO write bundle for cdc_write_packer.
// CDC_WRITE_PACKER_WORDCNT_EN adds the word_count signal.
interface cdc_write_packer_if #(
    parameter int IN_W   = 2,
    parameter int WORD_W = 10
);
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              fifo_full;
    logic              write_enable;
    logic [WORD_W-1:0] fifo_wdata;
    logic              fifo_wlast;
    logic              frame_done;
    logic              busy;
`ifdef CDC_WRITE_PACKER_WORDCNT_EN
    logic [15:0]       word_count;

    modport master (
        output in_data, in_valid, in_last, fifo_full,
        input  in_ready, write_enable, fifo_wdata, fifo_wlast,
        input  frame_done, busy, word_count
    );

    modport slave (
        input  in_data, in_valid, in_last, fifo_full,
        output in_ready, write_enable, fifo_wdata, fifo_wlast,
        output frame_done, busy, word_count
    );
`else
    modport master (
        output in_data, in_valid, in_last, fifo_full,
        input  in_ready, write_enable, fifo_wdata, fifo_wlast,
        input  frame_done, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, fifo_full,
        output in_ready, write_enable, fifo_wdata, fifo_wlast,
        output frame_done, busy
    );
`endif
endinterface

// File: rtl/cdc_write_packer.sv
// Write-domain packer: IN_W-bit beats into WORD_W-bit FIFO words, LSB first.
// Optional CDC_WRITE_PACKER_WORDCNT_EN adds a 16-bit written-word counter.
module cdc_write_packer #(
    parameter int IN_W   = 2,
    parameter int WORD_W = 10
) (
    input logic              write_clk,
    input logic              write_rst,
    cdc_write_packer_if.slave bus
);
    localparam int BEATS = WORD_W / IN_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [WORD_W-1:0] word_q;
    logic              last_q;
    logic              frame_done_q;
    logic              we;
    int                beat_idx;

    always_comb beat_idx = int'(beat_cnt_q) * IN_W;

    assign we = (state_q == HOLD) && !bus.fifo_full;

    assign bus.in_ready     = !write_rst && (state_q == FILL);
    assign bus.write_enable = we;
    assign bus.fifo_wdata   = word_q;
    assign bus.fifo_wlast   = last_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = (beat_cnt_q != '0) || (state_q == HOLD);

    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            state_q      <= FILL;
            beat_cnt_q   <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                FILL: begin
                    if (bus.in_valid) begin
                        // first beat zero-extends, so padding needs no extra step
                        if (beat_cnt_q == '0) begin
                            word_q <= WORD_W'(bus.in_data);
                        end else begin
                            word_q[beat_idx +: IN_W] <= bus.in_data;
                        end
                        if (beat_cnt_q == LAST_CNT || bus.in_last) begin
                            state_q    <= HOLD;
                            last_q     <= bus.in_last;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.fifo_full) begin
                        state_q      <= FILL;
                        frame_done_q <= last_q;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef CDC_WRITE_PACKER_WORDCNT_EN
    logic [15:0] word_count_q;

    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            word_count_q <= '0;
        end else if (we) begin
            word_count_q <= word_count_q + 16'd1;
        end
    end

    assign bus.word_count = word_count_q;
`endif

    a_hold_stable: assert property (
        @(posedge write_clk) disable iff (write_rst)
        (state_q == HOLD && bus.fifo_full)
        |=> (state_q == HOLD && $stable(word_q) && $stable(last_q))
    );

endmodule

// File: tb/tb_cdc_write_packer.sv
// Scoreboard bench for cdc_write_packer.
// A reference packer pushes expected words; the monitor pops on each write.
module tb_cdc_write_packer;
    localparam int IN_W   = 2;
    localparam int WORD_W = 10;
    localparam int BEATS  = WORD_W / IN_W;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cdc_write_packer_if #(.IN_W(IN_W), .WORD_W(WORD_W)) bus ();

    cdc_write_packer #(.IN_W(IN_W), .WORD_W(WORD_W)) dut (
        .write_clk(clk),
        .write_rst(rst),
        .bus      (bus)
    );

    int                n_chk = 0;
    int                n_err = 0;
    exp_t              sb[$];
    int                wcyc[$];
    exp_t              e;
    logic [WORD_W-1:0] m_word = '0;
    int                m_cnt  = 0;
    int                cyc    = 0;
    int                writes = 0;
    int                w0;
    logic [WORD_W-1:0] last_wdata = '0;
    logic              last_wlast = 1'b0;
    logic              fd_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            fd_exp = 1'b0;
        end else begin
            check("frame_done", 32'(bus.frame_done), 32'(fd_exp));
            fd_exp = 1'b0;
            if (bus.write_enable) begin
                check("we_while_full", 32'(bus.fifo_full), 0);
                if (sb.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("wdata", 32'(bus.fifo_wdata), 32'(e.data));
                    check("wlast", 32'(bus.fifo_wlast), 32'(e.last));
                    fd_exp = e.last;
                end
                writes++;
                wcyc.push_back(cyc);
                last_wdata = bus.fifo_wdata;
                last_wlast = bus.fifo_wlast;
            end
        end
    end

    // called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic [IN_W-1:0] d, input logic l);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = l;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (m_cnt == 0) m_word = '0;
        m_word[m_cnt*IN_W +: IN_W] = d;
        if (m_cnt == BEATS - 1 || l) begin
            sb.push_back({l, m_word});
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.fifo_full = 1'b0;
        tick(2);
        check("rst_ready", 32'(bus.in_ready), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_we", 32'(bus.write_enable), 0);
        check("rst_fd", 32'(bus.frame_done), 0);
`ifdef CDC_WRITE_PACKER_WORDCNT_EN
        check("rst_wcnt", 32'(bus.word_count), 0);
`endif
        rst = 1'b0;
        tick(1);
        check("ready_after_rst", 32'(bus.in_ready), 1);

        // basic word
        w0 = writes;
        send(2'b01, 0); send(2'b10, 0); send(2'b11, 0);
        send(2'b00, 0); send(2'b01, 0);
        check("t1_ready_hold", 32'(bus.in_ready), 0);
        check("t1_we", 32'(bus.write_enable), 1);
        tick(1);
        check("t1_ready_back", 32'(bus.in_ready), 1);
        check("t1_writes", writes - w0, 1);
        check("t1_word", 32'(last_wdata), 32'h139);
        check("t1_last", 32'(last_wlast), 0);

        // short frame
        send(2'b11, 0); send(2'b11, 0); send(2'b11, 1);
        check("t2_we", 32'(bus.write_enable), 1);
        tick(1);
        check("t2_fd", 32'(bus.frame_done), 1);
        check("t2_word", 32'(last_wdata), 32'h03F);
        check("t2_last", 32'(last_wlast), 1);

        // backpressure
        bus.fifo_full = 1'b1;
        w0 = writes;
        send(2'b10, 0); send(2'b01, 0); send(2'b00, 0);
        send(2'b11, 0); send(2'b10, 0);
        for (int i = 0; i < 4; i++) begin
            check("t3_we_low", 32'(bus.write_enable), 0);
            check("t3_ready_low", 32'(bus.in_ready), 0);
            check("t3_data", 32'(bus.fifo_wdata), 32'h2C6);
            tick(1);
        end
        bus.fifo_full = 1'b0;
        tick(1);
        check("t3_one_write", writes - w0, 1);
        check("t3_word", 32'(last_wdata), 32'h2C6);
        tick(3);
        check("t3_no_dup", writes - w0, 1);

        // streaming
        w0 = writes;
        wcyc.delete();
        for (int i = 0; i < 3 * BEATS; i++) send(IN_W'(i % 4), 0);
        tick(1);
        check("t4_writes", writes - w0, 3);
        check("t4_nwcyc", wcyc.size(), 3);
        if (wcyc.size() == 3) begin
            check("t4_gap0", wcyc[1] - wcyc[0], 6);
            check("t4_gap1", wcyc[2] - wcyc[1], 6);
        end
`ifdef CDC_WRITE_PACKER_WORDCNT_EN
        check("t4_wcnt", 32'(bus.word_count), writes);
`endif

        // reset mid-word
        send(2'b01, 0); send(2'b10, 0); send(2'b11, 0);
        check("t5_busy_pre", 32'(bus.busy), 1);
        w0 = writes;
        rst = 1'b1;
        m_cnt = 0;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t5_busy_rst", 32'(bus.busy), 0);
            check("t5_ready_rst", 32'(bus.in_ready), 0);
            check("t5_we_rst", 32'(bus.write_enable), 0);
            tick(1);
        end
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < BEATS; i++) send(2'b00, 0);
        tick(1);
        check("t5_writes", writes - w0, 1);
        check("t5_word", 32'(last_wdata), 0);
`ifdef CDC_WRITE_PACKER_WORDCNT_EN
        check("t5_wcnt", 32'(bus.word_count), 1);
`endif

        // last on final beat
        w0 = writes;
        send(2'b01, 0); send(2'b01, 0); send(2'b01, 0);
        send(2'b01, 0); send(2'b10, 1);
        tick(1);
        check("t6_fd", 32'(bus.frame_done), 1);
        check("t6_word", 32'(last_wdata), 32'h255);
        check("t6_last", 32'(last_wlast), 1);
        tick(5);
        check("t6_writes", writes - w0, 1);
        check("t6_busy", 32'(bus.busy), 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
